alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter that shares one 32-bit logic/arithmetic datapath (AND, OR, XOR, ADD) between up to four requesters. Each requester presents an opcode and two operands under a valid/ready handshake. The arbiter grants one requester per cycle, computes the result, and holds it in a single-entry output register tagged with the winner's ID until the consumer accepts it. It sits between the issue logic of the ALU cluster and the shared bitwise/adder units.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `WIDTH`, default 32: operand and result width.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: per-requester accept; at most one bit is set.
- `req_op` in 2*NUM_REQ: opcode, slice i for requester i; 00 AND, 01 OR, 10 XOR, 11 ADD.
- `req_a` in WIDTH*NUM_REQ: operand A, slice i.
- `req_b` in WIDTH*NUM_REQ: operand B, slice i.
- `rsp_valid` out 1: result register full.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out 2: index of the requester that owns `rsp_data`.
- `rsp_data` out WIDTH: registered result.

## Operation
- Output register states:
  - EMPTY (`rsp_valid`=0) → FULL on accept.
  - FULL → EMPTY on `rsp_valid & rsp_ready` with no new accept.
  - FULL → FULL on drain and accept in the same cycle (back-to-back).
- `can_accept` = `~rsp_valid | rsp_ready`.
- Grant is combinational:
  - Search valid requesters starting at `rr_ptr`, wrapping modulo NUM_REQ.
  - The first valid requester wins.
  - `req_ready[i]` = `grant[i] & can_accept`.
- Accept (`req_valid[i] & req_ready[i]`):
  - Load `rsp_data` with the op result.
  - Load `rsp_id` with i.
  - Set `rsp_valid`.
  - Set `rr_ptr` to (i+1) mod NUM_REQ.
- `rr_ptr` is unchanged when nothing is accepted, including when stalled by a FULL, unready output.
- Arithmetic:
  - AND, OR and XOR are bitwise over WIDTH bits.
  - ADD is unsigned, modulo 2^WIDTH; the carry is discarded.
- Requester rules:
  - Once asserted, `req_valid`, `req_op`, `req_a` and `req_b` are held stable until accepted.
  - The arbiter does not retract a grant from a stalled requester while `rr_ptr` is unchanged.
- Reset outputs: `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `req_ready`=0 (forced while `rst_n`=0), `rr_ptr`=0.
- Reset mid-operation discards any held result. No response is produced for it.

## Timing
- Latency is 1 cycle: a request accepted at edge N has `rsp_valid`=1 and the result after edge N.
- Throughput is one operation per cycle while `rsp_ready`=1.
- No combinational path from `req_*` to `rsp_*`.
- `req_ready` depends combinationally on `req_valid`, `rsp_valid`, `rsp_ready` and `rr_ptr`.
- Stall: with FULL and `rsp_ready`=0, all `req_ready`=0, and `rsp_data`/`rsp_id` hold.
- Simultaneous valids are resolved by `rr_ptr`. Starvation bound: a held request is accepted within NUM_REQ accepts.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined:
  - Round-robin is replaced by fixed priority; the lowest index wins.
  - `rr_ptr` is not implemented.
  - No starvation bound.
- Not defined: round-robin as described above.

## Structure
- Package `alu_arb_pkg` holds:
  - the op enum (`OP_AND`, `OP_OR`, `OP_XOR`, `OP_ADD`, 2 bits);
  - `ALU_WIDTH` = 32;
  - `MAX_REQ` = 4.
- Sub-module `alu_op_unit`:
  - Purely combinational: op, a, b in; result out.
  - Instantiates the team's bitwise units plus a WIDTH adder and a 4:1 mux.
- The arbiter holds the grant logic, `rr_ptr` and the output register.

## Test plan
- Reset, then single requests on requester 0:
  - OR: a=0x0000129F, b=0x00000BD2 → rsp_data=0x00001BDF, rsp_id=0, one cycle after accept.
  - ADD: a=0xFFFFFFFF, b=0x00000001 → rsp_data=0x00000000 (carry dropped).
- Contention, rr_ptr=0, both requesters valid:
  - Req0 AND 0xFFFFFFFF,0xA8492525; req1 XOR 0xFFFFFFFF,0xFFFFFFFF.
  - Grants alternate 0 then 1.
  - Responses are 0xA8492525 (id 0), then 0x00000000 (id 1), on consecutive cycles with rsp_ready=1.
- Backpressure:
  - Hold rsp_ready=0 for 3 cycles while FULL → req_ready=0, rsp_data stable.
  - Raise rsp_ready → drain and next accept in the same cycle, no bubble.
- Starvation, NUM_REQ=4, all valid continuously → grant order 0,1,2,3,0.
- Async reset mid-stall: assert rst_n=0 while FULL → rsp_valid=0, rsp_data=0, req_ready=0 immediately, without a clock edge; the first grant after release goes to requester 0.
- With `ALU_ARB_FIXED_PRIO_EN` and both requesters valid for 4 cycles → requester 0 is granted every cycle.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and sizing for the ALU arbiter slice.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (see alu_arbiter.sv).
package alu_arb_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int MAX_REQ   = 4;
    localparam int ID_W      = 2;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_op_unit.sv
// Combinational logic/arithmetic unit: bitwise AND/OR/XOR, modulo add, 4:1 select.
import alu_arb_pkg::*;

module alu_op_unit #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  alu_op_e            op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   result
);

    logic [WIDTH-1:0] and_res;
    logic [WIDTH-1:0] or_res;
    logic [WIDTH-1:0] xor_res;
    logic [WIDTH-1:0] sum_res;

    assign and_res = a & b;
    assign or_res  = a | b;
    assign xor_res = a ^ b;
    // Carry out is intentionally dropped: the sum wraps modulo 2^WIDTH.
    assign sum_res = a + b;

    always_comb begin
        // NOTE: assign a default before the case so no path leaves result unassigned (no latch).
        result = and_res;
        unique case (op)
            OP_AND: result = and_res;
            OP_OR:  result = or_res;
            OP_XOR: result = xor_res;
            OP_ADD: result = sum_res;
            default: result = and_res;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates up to MAX_REQ requesters onto one shared ALU with a single-entry result register.
// Define ALU_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
import alu_arb_pkg::*;

module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = ALU_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data
);

    logic              can_accept;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic              accept;
    alu_op_e           sel_op;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [WIDTH-1:0]  alu_result;

    assign can_accept = ~rsp_valid | rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest valid index is the last one written.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(k);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = grant_found && (grant_idx == ID_W'(i));
        end
    end

    assign accept = grant_found & can_accept;
    // rst_n gates the handshake directly so ready drops during reset without a clock.
    assign req_ready = grant & {NUM_REQ{can_accept & rst_n}};

    always_comb begin
        int sel;
        sel    = int'(grant_idx);
        sel_op = alu_op_e'(req_op[sel*2 +: 2]);
        sel_a  = req_a[sel*WIDTH +: WIDTH];
        sel_b  = req_b[sel*WIDTH +: WIDTH];
    end

    alu_op_unit #(.WIDTH(WIDTH)) u_alu (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result;
            rsp_id    <= grant_idx;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with four requesters.
// Honours ALU_ARB_FIXED_PRIO_EN to select the priority expectations.
`timescale 1ns/1ps
import alu_arb_pkg::*;

module tb_alu_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[2*i +: 2] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b0;
        req_valid = 4'b0001; req_op = '0; req_a = '0; req_b = '0;
        #3;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rsp_data); end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", rsp_id); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_or();
        rsp_ready = 1'b1;
        set_req(0, OP_OR, 32'h0000129F, 32'h00000BD2);
        req_valid = 4'b0001;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL or_ready: got %b expected 0001", req_ready); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL or_valid: got %b expected 1", rsp_valid); end
        n_checks++; if (rsp_data !== 32'h00001BDF) begin n_fail++; $display("FAIL or_data: got %h expected 00001bdf", rsp_data); end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL or_id: got %0d expected 0", rsp_id); end
    endtask

    task automatic test_single_add();
        set_req(0, OP_ADD, 32'hFFFFFFFF, 32'h00000001);
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL add_ready: got %b expected 0001", req_ready); end
        @(negedge clk);
        n_checks++; if (rsp_data !== 32'h00000000) begin n_fail++; $display("FAIL add_data: got %h expected 00000000", rsp_data); end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", rsp_valid); end
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_contention();
        reset_pulse();
        rsp_ready = 1'b1;
        set_req(0, OP_AND, 32'hFFFFFFFF, 32'hA8492525);
        set_req(1, OP_XOR, 32'hFFFFFFFF, 32'hFFFFFFFF);
        req_valid = 4'b0011;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL cont_grant0: got %b expected 0001", req_ready); end
        @(negedge clk);
        n_checks++; if (rsp_data !== 32'hA8492525 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL cont_rsp0: got %h/%0d expected a8492525/0", rsp_data, rsp_id); end
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL cont_grant1: got %b expected 0010", req_ready); end
        @(negedge clk);
        n_checks++; if (rsp_data !== 32'h00000000 || rsp_id !== 2'd1 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL cont_rsp1: got %h/%0d v%b expected 00000000/1 v1", rsp_data, rsp_id, rsp_valid); end
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL cont_grant2: got %b expected 0001", req_ready); end
        @(negedge clk);
        n_checks++; if (rsp_data !== 32'hA8492525 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL cont_rsp2: got %h/%0d expected a8492525/0", rsp_data, rsp_id); end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(0, OP_OR, 32'h0F0F0000, 32'h000000F0);
        req_valid = 4'b0001;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_first_ready: got %b expected 0001", req_ready); end
        @(negedge clk);
        n_checks++; if (rsp_data !== 32'h0F0F00F0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_first_rsp: got %h/%0d expected 0f0f00f0/0", rsp_data, rsp_id); end
        set_req(1, OP_ADD, 32'h00000005, 32'h00000007);
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0000", c, req_ready); end
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0F0F00F0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_hold[%0d]: got v%b %h/%0d expected v1 0f0f00f0/0", c, rsp_valid, rsp_data, rsp_id); end
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", req_ready); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000000C || rsp_id !== 2'd1) begin n_fail++; $display("FAIL bp_no_bubble: got v%b %h/%0d expected v1 0000000c/1", rsp_valid, rsp_data, rsp_id); end
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_starvation();
        logic [3:0] exp_ready;
        reset_pulse();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, OP_XOR, W'(i), 32'h00000100);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_ready = 4'b0001 << (k % N);
            #1;
            n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL starve_grant[%0d]: got %b expected %b", k, req_ready, exp_ready); end
            @(negedge clk);
            n_checks++; if (rsp_id !== 2'(k % N) || rsp_data !== (32'h100 | W'(k % N))) begin n_fail++; $display("FAIL starve_rsp[%0d]: got %h/%0d expected %h/%0d", k, rsp_data, rsp_id, 32'h100 | W'(k % N), k % N); end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        rsp_ready = 1'b0;
        set_req(2, OP_ADD, 32'h00000001, 32'h00000002);
        req_valid = 4'b0100;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rst_stall_ready: got %b expected 0100", req_ready); end
        @(negedge clk);
        n_checks++; if (rsp_data !== 32'h00000003 || rsp_id !== 2'd2) begin n_fail++; $display("FAIL rst_stall_rsp: got %h/%0d expected 00000003/2", rsp_data, rsp_id); end
        set_req(0, OP_AND, 32'h000000F0, 32'h000000FF);
        set_req(1, OP_OR, 32'h00000001, 32'h00000002);
        req_valid = 4'b0111;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_stall_blocked: got %b expected 0000", req_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL rst_async_rsp: got v%b %h/%0d expected v0 0/0", rsp_valid, rsp_data, rsp_id); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_async_ready: got %b expected 0000", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_first_grant: got %b expected 0001", req_ready); end
        @(negedge clk);
        n_checks++; if (rsp_id !== 2'd0 || rsp_data !== 32'h000000F0) begin n_fail++; $display("FAIL rst_first_rsp: got %h/%0d expected 000000f0/0", rsp_data, rsp_id); end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_fixed_prio();
        rsp_ready = 1'b1;
        set_req(0, OP_AND, 32'hFFFFFFFF, 32'hA8492525);
        set_req(1, OP_XOR, 32'hFFFFFFFF, 32'hFFFFFFFF);
        req_valid = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL fixed_grant[%0d]: got %b expected 0001", k, req_ready); end
            @(negedge clk);
            n_checks++; if (rsp_id !== 2'd0 || rsp_data !== 32'hA8492525) begin n_fail++; $display("FAIL fixed_rsp[%0d]: got %h/%0d expected a8492525/0", k, rsp_data, rsp_id); end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_or();
        test_single_add();
`ifdef ALU_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_contention();
`endif
        test_backpressure();
`ifndef ALU_ARB_FIXED_PRIO_EN
        test_starvation();
`endif
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
